ds_operand_scoreboard: RTL and testbench

Parametrised operand-resolution and hazard unit for the decode stage. It supersedes the fixed three-stage bypass with a generalised version that supports any number of forwarding producers and read ports. It also adds a per-register scoreboard for long-latency writers, such as the multi-cycle divider, and a stall-cycle performance counter. It sits between the regfile read ports and the decode outputs, and drives the decode stage's ready_go.

---
 rtl/ds_operand_scoreboard_if.sv | 44 ++++
 rtl/ds_operand_scoreboard.sv | 106 ++++++++++
 tb/tb_ds_operand_scoreboard.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ds_operand_scoreboard_if.sv
// Decode-stage operand bus: regfile data, forwarding producers, long-latency completion, resolved operands.
// master drives decode/producer inputs; slave (the scoreboard) returns operands, stall and status.
interface ds_operand_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NFWD = 3
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic                 ds_valid;
  logic                 ds_fire;
  logic [NSRC*AW-1:0]   ds_src_addr;
  logic [NSRC-1:0]      ds_src_need;
  logic                 ds_rf_we;
  logic [AW-1:0]        ds_rf_waddr;
  logic                 ds_long;
  logic [NSRC*XLEN-1:0] rf_rdata;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*AW-1:0]   fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic [NFWD-1:0]      fwd_ready;
  logic                 long_done;
  logic [AW-1:0]        long_waddr;
  logic                 flush;
  logic [NSRC*XLEN-1:0] src_value;
  logic                 ds_stall;
  logic                 sb_busy;
  logic [CW-1:0]        sb_count;
  logic [31:0]          stall_cycles;

  modport master (
    output ds_valid, ds_fire, ds_src_addr, ds_src_need, ds_rf_we, ds_rf_waddr, ds_long,
           rf_rdata, fwd_we, fwd_waddr, fwd_wdata, fwd_ready, long_done, long_waddr, flush,
    input  src_value, ds_stall, sb_busy, sb_count, stall_cycles
  );

  modport slave (
    input  ds_valid, ds_fire, ds_src_addr, ds_src_need, ds_rf_we, ds_rf_waddr, ds_long,
           rf_rdata, fwd_we, fwd_waddr, fwd_wdata, fwd_ready, long_done, long_waddr, flush,
    output src_value, ds_stall, sb_busy, sb_count, stall_cycles
  );
endinterface

// File: rtl/ds_operand_scoreboard.sv
// Decode operand resolution: N-producer bypass, load-use/RAW/WAW hazards, long-write scoreboard, stall counter.
// Operands and ds_stall are zero-latency combinational; scoreboard and counter update at the clock edge.
module ds_operand_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NFWD = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  ds_operand_scoreboard_if.slave io
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NREG-1:0]      sb_q, sb_d;
  logic [NREG-1:0]      done_vec, hit_vec;
  logic [CW-1:0]        sb_count_q, sb_count_d;
  logic [31:0]          stall_cycles_q, stall_cycles_d;
  logic [AW-1:0]        src_addr [NSRC];
  logic [NSRC-1:0]      fwd_hit, fwd_rdy, lu_stall, raw_stall;
  logic [NSRC*XLEN-1:0] src_value;
  logic                 waw_stall, ds_stall, sb_set;

  // Scan oldest to youngest so the youngest matching producer overwrites last.
  always_comb begin
    src_value = io.rf_rdata;
    fwd_hit   = '0;
    fwd_rdy   = '1;
    for (int i = 0; i < NSRC; i++) begin
      src_addr[i] = io.ds_src_addr[i*AW +: AW];
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (io.fwd_we[k] && (io.fwd_waddr[k*AW +: AW] == src_addr[i]) && (src_addr[i] != '0)) begin
          fwd_hit[i]                = 1'b1;
          fwd_rdy[i]                = io.fwd_ready[k];
          src_value[i*XLEN +: XLEN] = io.fwd_wdata[k*XLEN +: XLEN];
        end
      end
    end
    if (!resetn) begin
      src_value = io.rf_rdata;
    end
  end

  // A register completing this cycle no longer blocks; its value arrives via the oldest producer.
  always_comb begin
    done_vec = '0;
    if (io.long_done) begin
      done_vec[io.long_waddr] = 1'b1;
    end
    hit_vec   = sb_q & ~done_vec;
    lu_stall  = '0;
    raw_stall = '0;
    for (int i = 0; i < NSRC; i++) begin
      lu_stall[i]  = io.ds_src_need[i] & fwd_hit[i] & ~fwd_rdy[i];
      raw_stall[i] = io.ds_src_need[i] & hit_vec[src_addr[i]];
    end
    waw_stall = io.ds_rf_we & (io.ds_rf_waddr != '0) & hit_vec[io.ds_rf_waddr];
    ds_stall  = resetn & io.ds_valid & ((|lu_stall) | (|raw_stall) | waw_stall);
  end

  // Clear before set so a same-register set/clear leaves the bit pending.
  always_comb begin
    sb_set = io.ds_fire & io.ds_rf_we & io.ds_long & (io.ds_rf_waddr != '0);
    sb_d   = sb_q;
    if (io.flush) begin
      sb_d = '0;
    end else begin
      if (io.long_done) begin
        sb_d[io.long_waddr] = 1'b0;
      end
      if (sb_set) begin
        sb_d[io.ds_rf_waddr] = 1'b1;
      end
    end
    sb_d[0] = 1'b0;

    sb_count_d = '0;
    for (int r = 1; r < NREG; r++) begin
      sb_count_d = sb_count_d + CW'(sb_d[r]);
    end

    stall_cycles_d = stall_cycles_q;
    if (ds_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_q           <= '0;
      sb_count_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      sb_q           <= sb_d;
      sb_count_q     <= sb_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign io.src_value    = src_value;
  assign io.ds_stall     = ds_stall;
  assign io.sb_busy      = (sb_count_q != '0);
  assign io.sb_count     = sb_count_q;
  assign io.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_ds_operand_scoreboard.sv
// Bench for ds_operand_scoreboard: directed scenarios plus random traffic against a queue-based reference model.
// The driver pushes expected outputs each cycle; the negedge monitor pops and compares.
module tb_ds_operand_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NSRC = 2;
  localparam int NFWD = 3;
  localparam int AW   = 5;
  localparam int CW   = 6;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ds_operand_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC), .NFWD(NFWD)) bus ();

  ds_operand_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC), .NFWD(NFWD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (bus)
  );

  typedef struct {
    logic [NSRC*XLEN-1:0] src;
    logic                 stall;
    logic [CW-1:0]        cnt;
    logic                 busy;
    logic [31:0]          sc;
  } exp_t;

  exp_t            expq[$];
  exp_t            mon_e;
  int              checks = 0;
  int              errors = 0;
  bit              pend [NREG];
  longint unsigned m_sc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("src_value",    64'(bus.src_value),    64'(mon_e.src));
      chk("ds_stall",     64'(bus.ds_stall),     64'(mon_e.stall));
      chk("sb_count",     64'(bus.sb_count),     64'(mon_e.cnt));
      chk("sb_busy",      64'(bus.sb_busy),      64'(mon_e.busy));
      chk("stall_cycles", 64'(bus.stall_cycles), 64'(mon_e.sc));
    end
  end

  function automatic int pend_count();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(pend[r]);
    return n;
  endfunction

  function automatic bit pending_now(input int r);
    return pend[r] && !(bus.long_done && int'(bus.long_waddr) == r);
  endfunction

  // Reference: youngest matching producer wins, r0 never forwards, pending long writes block readers/writers.
  function automatic exp_t model_out();
    exp_t e;
    bit   any;
    bit   found;
    bit   rdy;
    int   a;
    e.src = bus.rf_rdata;
    any   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      a     = int'(bus.ds_src_addr[i*AW +: AW]);
      found = 1'b0;
      rdy   = 1'b1;
      if (a != 0) begin
        for (int k = 0; k < NFWD; k++) begin
          if (!found && bus.fwd_we[k] && int'(bus.fwd_waddr[k*AW +: AW]) == a) begin
            found = 1'b1;
            rdy   = bus.fwd_ready[k];
            e.src[i*XLEN +: XLEN] = bus.fwd_wdata[k*XLEN +: XLEN];
          end
        end
      end
      if (bus.ds_src_need[i] && ((found && !rdy) || pending_now(a))) any = 1'b1;
    end
    if (bus.ds_rf_we && bus.ds_rf_waddr != 0 && pending_now(int'(bus.ds_rf_waddr))) any = 1'b1;
    e.stall = bus.ds_valid && any;
    if (!resetn) begin
      e.src   = bus.rf_rdata;
      e.stall = 1'b0;
    end
    e.cnt  = CW'(pend_count());
    e.busy = (pend_count() != 0);
    e.sc   = m_sc[31:0];
    return e;
  endfunction

  task automatic reset_model();
    for (int r = 0; r < NREG; r++) pend[r] = 1'b0;
    m_sc = 0;
  endtask

  // Called at posedge+1 with inputs applied; the monitor consumes the entry at the following negedge.
  task automatic step(input bit auto_fire);
    exp_t e;
    e = model_out();
    if (auto_fire) bus.ds_fire = bus.ds_valid && !e.stall && ($urandom_range(0, 3) != 0);
    expq.push_back(e);
    if (!resetn) begin
      reset_model();
    end else begin
      if (e.stall && m_sc != 64'hFFFF_FFFF) m_sc++;
      if (bus.flush) begin
        for (int r = 0; r < NREG; r++) pend[r] = 1'b0;
      end else begin
        if (bus.long_done) pend[int'(bus.long_waddr)] = 1'b0;
        if (bus.ds_fire && bus.ds_rf_we && bus.ds_long && bus.ds_rf_waddr != 0)
          pend[int'(bus.ds_rf_waddr)] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ds_valid    = 1'b0;
    bus.ds_fire     = 1'b0;
    bus.ds_src_addr = '0;
    bus.ds_src_need = '0;
    bus.ds_rf_we    = 1'b0;
    bus.ds_rf_waddr = '0;
    bus.ds_long     = 1'b0;
    bus.rf_rdata    = {$urandom(), $urandom()};
    bus.fwd_we      = '0;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = {$urandom(), $urandom(), $urandom()};
    bus.fwd_ready   = '1;
    bus.long_done   = 1'b0;
    bus.long_waddr  = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_src(input int i, input int addr, input bit need);
    bus.ds_src_addr[i*AW +: AW] = AW'(addr);
    bus.ds_src_need[i]          = need;
  endtask

  task automatic set_fwd(input int k, input int addr, input logic [XLEN-1:0] data, input bit rdy);
    bus.fwd_we[k]                 = 1'b1;
    bus.fwd_waddr[k*AW +: AW]     = AW'(addr);
    bus.fwd_wdata[k*XLEN +: XLEN] = data;
    bus.fwd_ready[k]              = rdy;
  endtask

  task automatic long_write(input int addr, input bit fire);
    bus.ds_valid    = 1'b1;
    bus.ds_fire     = fire;
    bus.ds_rf_we    = 1'b1;
    bus.ds_long     = 1'b1;
    bus.ds_rf_waddr = AW'(addr);
  endtask

  task automatic rand_cycle();
    idle();
    bus.ds_valid = ($urandom_range(0, 7) != 0);
    for (int i = 0; i < NSRC; i++) set_src(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    for (int k = 0; k < NFWD; k++) begin
      if ($urandom_range(0, 1) != 0) set_fwd(k, $urandom_range(0, 7), $urandom(), ($urandom_range(0, 3) != 0));
    end
    bus.ds_rf_we     = 1'($urandom_range(0, 1));
    bus.ds_rf_waddr  = AW'($urandom_range(0, 7));
    bus.ds_long      = ($urandom_range(0, 2) == 0);
    bus.long_done    = ($urandom_range(0, 3) == 0);
    bus.long_waddr   = AW'($urandom_range(0, 7));
    bus.flush        = ($urandom_range(0, 39) == 0);
    step(1'b1);
  endtask

  initial begin
    reset_model();
    idle();
    @(posedge clk);
    #1;
    step(1'b0);
    step(1'b0);
    resetn = 1'b1;

    // Three producers write r5; EX must win.
    idle(); bus.ds_valid = 1'b1; set_src(0, 5, 1'b1);
    set_fwd(0, 5, 32'h11, 1'b1); set_fwd(1, 5, 32'h22, 1'b1); set_fwd(2, 5, 32'h33, 1'b1);
    step(1'b0);

    // Load in EX, then the same load in MEM.
    idle(); bus.ds_valid = 1'b1; set_src(0, 7, 1'b1); set_fwd(0, 7, 32'h7777, 1'b0); step(1'b0);
    idle(); bus.ds_valid = 1'b1; set_src(0, 7, 1'b1); set_fwd(1, 7, 32'h7777, 1'b1); step(1'b0);

    // Divider to r9, consumer waits, released by long_done through WB.
    idle(); long_write(9, 1'b1); step(1'b0);
    repeat (10) begin
      idle(); bus.ds_valid = 1'b1; set_src(0, 9, 1'b1); step(1'b0);
    end
    idle(); bus.ds_valid = 1'b1; set_src(0, 9, 1'b1);
    bus.long_done = 1'b1; bus.long_waddr = 5'd9; set_fwd(2, 9, 32'hDEAD, 1'b1);
    step(1'b0);
    idle(); step(1'b0);

    // WAW on r4, then set and clear of r4 in the same cycle.
    idle(); long_write(4, 1'b1); step(1'b0);
    repeat (3) begin
      idle(); long_write(4, 1'b0); step(1'b0);
    end
    idle(); long_write(4, 1'b1); bus.long_done = 1'b1; bus.long_waddr = 5'd4; step(1'b0);
    idle(); step(1'b0);

    // Several pending writes, then flush racing a new set.
    idle(); long_write(10, 1'b1); step(1'b0);
    idle(); long_write(11, 1'b1); step(1'b0);
    idle(); long_write(12, 1'b1); step(1'b0);
    idle(); long_write(13, 1'b1); bus.flush = 1'b1; step(1'b0);
    idle(); step(1'b0);

    // Sources of r0 ignore a producer writing r0, even an unready one.
    idle(); bus.ds_valid = 1'b1; set_src(0, 0, 1'b1); set_src(1, 0, 1'b1);
    set_fwd(0, 0, 32'hBAD0, 1'b0);
    step(1'b0);

    repeat (3000) rand_cycle();

    // Asynchronous reset between edges with pending state and a stalled consumer.
    idle(); bus.flush = 1'b1; step(1'b0);
    idle(); long_write(3, 1'b1); step(1'b0);
    idle(); bus.ds_valid = 1'b1; set_src(0, 3, 1'b1); step(1'b0);
    idle(); bus.ds_valid = 1'b1; set_src(0, 3, 1'b1);
    #2;
    resetn = 1'b0;
    reset_model();
    step(1'b0);
    idle(); step(1'b0);
    resetn = 1'b1;
    idle(); step(1'b0);
    idle(); bus.ds_valid = 1'b1; set_src(1, 3, 1'b1); step(1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
